// File: rtl/rib_pkg.sv
// rtl/rib_pkg.sv - shared constants for the RIB master arbiter
//
// Purpose: master count, master index map, index width and FSM state codes
// used by the arbiter, its interface and the rotating priority encoder.
package rib_pkg;

    localparam int N_MASTERS = 4;
    localparam int IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    // Master index map on the RIB interconnect
    localparam int M_CORE_EX  = 0;
    localparam int M_CORE_PC  = 1;
    localparam int M_JTAG     = 2;
    localparam int M_UART_DBG = 3;

    // Arbiter FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/rib_arbiter_if.sv
// rtl/rib_arbiter_if.sv - request/grant bundle between RIB masters and the arbiter
//
// Signals (named from the arbiter's point of view):
//   req_i       per-master request, level
//   lock_i      per-master request to keep the grant
//   gnt_o       one-hot grant, registered
//   gnt_idx_o   binary index of the owner, registered
//   gnt_valid_o grant present, registered
//   hold_flag_o some requester is waiting (combinational)
// Modports: master (request side), slave (arbiter side).
interface rib_arbiter_if;
    import rib_pkg::*;

    logic [N_MASTERS-1:0] req_i;
    logic [N_MASTERS-1:0] lock_i;
    logic [N_MASTERS-1:0] gnt_o;
    logic [IDX_W-1:0]     gnt_idx_o;
    logic                 gnt_valid_o;
    logic                 hold_flag_o;

    modport master (
        output req_i,
        output lock_i,
        input  gnt_o,
        input  gnt_idx_o,
        input  gnt_valid_o,
        input  hold_flag_o
    );

    modport slave (
        input  req_i,
        input  lock_i,
        output gnt_o,
        output gnt_idx_o,
        output gnt_valid_o,
        output hold_flag_o
    );

endinterface

// File: rtl/rib_rr_pick.sv
// rtl/rib_rr_pick.sv - combinational rotating priority encoder
//
// Picks the first set bit of (req_i & ~exclude_i), searching from last_i+1
// and wrapping around. With last_i = N_MASTERS-1 it reduces to a plain
// lowest-index priority encoder.
// Ports:
//   req_i     in  N_MASTERS  candidate vector
//   last_i    in  IDX_W      previous winner; search starts one above it
//   exclude_i in  N_MASTERS  bits removed from the search
//   gnt_o     out N_MASTERS  one-hot winner, zero when none
//   idx_o     out IDX_W      winner index, zero when none
//   any_o     out 1          a winner exists
module rib_rr_pick
    import rib_pkg::*;
(
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_i,
    input  logic [N_MASTERS-1:0] exclude_i,
    output logic [N_MASTERS-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_o
);

    logic [N_MASTERS-1:0] cand;
    logic [IDX_W-1:0]     pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = '0;
        cand  = req_i & ~exclude_i;
        for (int k = 1; k <= N_MASTERS; k++) begin
            pos = IDX_W'((int'(last_i) + k) % N_MASTERS);
            if (!any_o && cand[pos]) begin
                any_o = 1'b1;
                idx_o = pos;
            end
        end
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/rib_arbiter.sv
// rtl/rib_arbiter.sv - registered round-robin arbiter for the RIB masters
//
// One-hot registered grant for the four RIB masters. Masters in HP_MASK win
// over round-robin and preempt non-HP owners; the rest rotate fairly. An
// owner may keep the bus with lock while others wait for at most MAX_HOLD
// consecutive cycles.
// Ports:
//   clk     in  single clock
//   rst     in  synchronous active-high reset
//   rib_if  slave modport: req_i, lock_i in; gnt_o, gnt_idx_o, gnt_valid_o,
//           hold_flag_o out
module rib_arbiter
    import rib_pkg::*;
#(
    parameter int                   MAX_HOLD = 16,
    parameter logic [N_MASTERS-1:0] HP_MASK  = 4'b0100
) (
    input  logic          clk,
    input  logic          rst,
    rib_arbiter_if.slave  rib_if
);

    // Counter is at least one bit wide so MAX_HOLD = 1 still elaborates;
    // HOLD_LAST = 0 then makes every lock request fail the bound check.
    localparam int              HC_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    logic [0:0]           state_q, state_d;
    logic [N_MASTERS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [HC_W-1:0]      hold_cnt_q, hold_cnt_d;

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] hp_req;
    logic [N_MASTERS-1:0] rr_gnt, hp_gnt, win_gnt;
    logic [IDX_W-1:0]     rr_idx, hp_idx, win_idx;
    logic                 rr_any, hp_any;
    logic                 own_req, own_lock, own_hp, others, hp_other;
    logic                 do_switch;

    assign req    = rib_if.req_i;
    assign hp_req = req & HP_MASK;

    // The current owner is always excluded from both searches: it only
    // matters on a forced handover, where the owner must not re-win.
    rib_rr_pick u_rr_pick (
        .req_i     (req),
        .last_i    (last_q),
        .exclude_i (gnt_q),
        .gnt_o     (rr_gnt),
        .idx_o     (rr_idx),
        .any_o     (rr_any)
    );

    // Fixed lowest-index pick among HP requesters
    rib_rr_pick u_hp_pick (
        .req_i     (hp_req),
        .last_i    (IDX_W'(N_MASTERS - 1)),
        .exclude_i (gnt_q),
        .gnt_o     (hp_gnt),
        .idx_o     (hp_idx),
        .any_o     (hp_any)
    );

    assign win_gnt = hp_any ? hp_gnt : rr_gnt;
    assign win_idx = hp_any ? hp_idx : rr_idx;

    assign own_req  = |(req & gnt_q);
    assign own_lock = |(req & rib_if.lock_i & gnt_q);
    assign own_hp   = |(gnt_q & HP_MASK);
    assign others   = |(req & ~gnt_q);
    assign hp_other = |(hp_req & ~gnt_q);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        do_switch  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    do_switch = 1'b1;
                end
            end
            default: begin
                if (!own_req) begin
                    // Owner released: hand over with no bubble, or go idle
                    if (others) begin
                        do_switch = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                    end
                end else if (hp_other && !own_hp) begin
                    do_switch = 1'b1;
                end else if (!others) begin
                    if (hold_cnt_q != HOLD_LAST) begin
                        hold_cnt_d = hold_cnt_q + HC_W'(1);
                    end
                end else if (own_lock && (hold_cnt_q < HOLD_LAST)) begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end else begin
                    do_switch = 1'b1;
                end
            end
        endcase

        if (do_switch && (hp_any || rr_any)) begin
            state_d    = ST_GRANT;
            gnt_d      = win_gnt;
            idx_d      = win_idx;
            valid_d    = 1'b1;
            last_d     = win_idx;
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= IDX_W'(N_MASTERS - 1);
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign rib_if.gnt_o       = gnt_q;
    assign rib_if.gnt_idx_o   = idx_q;
    assign rib_if.gnt_valid_o = valid_q;
    assign rib_if.hold_flag_o = |(req & ~gnt_q);

endmodule

// File: tb/tb_rib_arbiter.sv
// tb/tb_rib_arbiter.sv - self-checking bench for rib_arbiter
module tb_rib_arbiter;
    import rib_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;

    int n_vec = 0;
    int n_err = 0;

    rib_arbiter_if if_a ();
    rib_arbiter_if if_b ();

    assign if_a.req_i  = req;
    assign if_a.lock_i = lock;
    assign if_b.req_i  = req;
    assign if_b.lock_i = lock;

    // u_a: default JTAG high priority; u_b: pure round-robin
    rib_arbiter #(.MAX_HOLD(16), .HP_MASK(4'b0100)) u_a (
        .clk    (clk),
        .rst    (rst),
        .rib_if (if_a.slave)
    );

    rib_arbiter #(.MAX_HOLD(16), .HP_MASK(4'b0000)) u_b (
        .clk    (clk),
        .rst    (rst),
        .rib_if (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         sel;
        bit         r;
        logic [3:0] req;
        logic [3:0] lock;
        logic [3:0] gnt;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl[$];

    // Apply one cycle of stimulus, clock it, then compare the selected DUT.
    task automatic step(input bit sel, input bit r, input logic [3:0] rq,
                        input logic [3:0] lk, input logic [3:0] eg,
                        input logic [1:0] ei, input string nm);
        logic [3:0] g;
        logic [1:0] ix;
        logic       v, h, ev, eh;
        @(negedge clk);
        rst  = r;
        req  = rq;
        lock = lk;
        @(posedge clk);
        #1;
        g  = sel ? if_b.gnt_o       : if_a.gnt_o;
        ix = sel ? if_b.gnt_idx_o   : if_a.gnt_idx_o;
        v  = sel ? if_b.gnt_valid_o : if_a.gnt_valid_o;
        h  = sel ? if_b.hold_flag_o : if_a.hold_flag_o;
        ev = |eg;
        eh = |(rq & ~eg);
        n_vec++;
        if (g !== eg || ix !== ei || v !== ev || h !== eh) begin
            n_err++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b hold=%b, want gnt=%b idx=%0d valid=%b hold=%b",
                     nm, g, ix, v, h, eg, ei, ev, eh);
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        lock = '0;

        // DUT A: reset with all requesting, then JTAG wins first
        tbl.push_back('{0, 1, 4'b1111, 4'b0000, 4'b0000, 2'd0});
        tbl.push_back('{0, 1, 4'b1111, 4'b0000, 4'b0000, 2'd0});
        tbl.push_back('{0, 0, 4'b1111, 4'b0000, 4'b0100, 2'd2});
        // DUT A: preemption of a locked owner and return
        tbl.push_back('{0, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0});
        tbl.push_back('{0, 0, 4'b0010, 4'b0010, 4'b0010, 2'd1});
        tbl.push_back('{0, 0, 4'b0010, 4'b0010, 4'b0010, 2'd1});
        tbl.push_back('{0, 0, 4'b0110, 4'b0010, 4'b0100, 2'd2});
        tbl.push_back('{0, 0, 4'b0110, 4'b0110, 4'b0100, 2'd2});
        tbl.push_back('{0, 0, 4'b0010, 4'b0010, 4'b0010, 2'd1});
        // DUT A: owner 3 releases as HP and master 0 request; HP wins over rr
        tbl.push_back('{0, 0, 4'b1000, 4'b0000, 4'b1000, 2'd3});
        tbl.push_back('{0, 0, 4'b0101, 4'b0000, 4'b0100, 2'd2});
        tbl.push_back('{0, 0, 4'b0001, 4'b0000, 4'b0001, 2'd0});
        tbl.push_back('{0, 0, 4'b1000, 4'b0000, 4'b1000, 2'd3});
        // Idle keeps the last index
        tbl.push_back('{0, 0, 4'b0000, 4'b0000, 4'b0000, 2'd3});
        // DUT B: plain round-robin over 1011
        tbl.push_back('{1, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0});
        tbl.push_back('{1, 0, 4'b1011, 4'b0000, 4'b0001, 2'd0});
        tbl.push_back('{1, 0, 4'b1011, 4'b0000, 4'b0010, 2'd1});
        tbl.push_back('{1, 0, 4'b1011, 4'b0000, 4'b1000, 2'd3});
        tbl.push_back('{1, 0, 4'b1011, 4'b0000, 4'b0001, 2'd0});
        // DUT B: no HP mask, so master 2 cannot preempt a locked owner
        tbl.push_back('{1, 0, 4'b0101, 4'b0001, 4'b0001, 2'd0});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].sel, tbl[i].r, tbl[i].req, tbl[i].lock,
                 tbl[i].gnt, tbl[i].idx, $sformatf("tbl%0d", i));
        end

        // Lock bound: master 0 holds 16 cycles, master 1 gets one, repeat
        step(1, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0, "lock_rst");
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 16; k++) begin
                step(1, 0, 4'b0011, 4'b0001, 4'b0001, 2'd0, $sformatf("lock_hold%0d_%0d", rep, k));
            end
            step(1, 0, 4'b0011, 4'b0001, 4'b0010, 2'd1, $sformatf("lock_yield%0d", rep));
        end

        // Sole requester keeps the bus indefinitely, then idles
        step(1, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0, "sole_rst");
        for (int k = 0; k < 40; k++) begin
            step(1, 0, 4'b0001, 4'b0000, 4'b0001, 2'd0, $sformatf("sole%0d", k));
        end
        step(1, 0, 4'b0000, 4'b0000, 4'b0000, 2'd0, "sole_idle");

        // Reset during a lock hold; the hold budget restarts from zero
        step(1, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0, "mid_rst0");
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 4'b0011, 4'b0001, 4'b0001, 2'd0, $sformatf("mid_pre%0d", k));
        end
        step(1, 1, 4'b0011, 4'b0001, 4'b0000, 2'd0, "mid_rst1");
        step(1, 0, 4'b0001, 4'b0001, 4'b0001, 2'd0, "mid_restart");
        for (int k = 0; k < 15; k++) begin
            step(1, 0, 4'b0011, 4'b0001, 4'b0001, 2'd0, $sformatf("mid_hold%0d", k));
        end
        step(1, 0, 4'b0011, 4'b0001, 4'b0010, 2'd1, "mid_yield");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
